calc1_arbiter: RTL and testbench
================================

CALC1_ARBITER -- requirements
Module: calc1_arbiter

Interface
REQ-001 Parameter ALU_TIMEOUT, default 15, max cycles in WAIT before the operation is aborted.
REQ-002 c_clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  reset; asynchronous, active-low.
REQ-004 req_cmd_in[1:4]  in  4 each  per-port command: 0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH.
REQ-005 req_data_in[1:4]  in  32 each  per-port operand, bits [0:31].
REQ-006 out_resp[1:4]  out  2 each  per-port response: 0 none, 1 success, 2 overflow/underflow/invalid, 3 timeout.
REQ-007 out_data[1:4]  out  32 each  per-port result.
REQ-008 alu_req  out  1  one-cycle issue strobe to the shared ALU.
REQ-009 alu_cmd  out  4  command issued.
REQ-010 alu_op1, alu_op2  out  32 each  operands issued.
REQ-011 alu_done  in  1  ALU completion strobe.
REQ-012 alu_resp  in  2  ALU response code, valid with alu_done.
REQ-013 alu_data  in  32  ALU result, valid with alu_done.

Function
REQ-014 Each port SHALL run its own capture FSM: P_IDLE, P_OP2, P_PEND.
REQ-015 In P_IDLE, a nonzero req_cmd_in SHALL latch cmd and req_data_in as op1, then move to P_OP2.
REQ-016 In P_OP2, req_data_in SHALL be latched as op2 regardless of req_cmd_in.
REQ-017 From P_OP2, a valid cmd (1,2,5,6) SHALL move to P_PEND.
REQ-018 From P_OP2, an invalid cmd SHALL go to P_IDLE and drive out_resp=2, out_data=0 for exactly the next cycle, bypassing the arbiter.
REQ-019 In P_OP2 and P_PEND, nonzero commands on that port SHALL be ignored and dropped.
REQ-020 Scheduler FSM SHALL have states S_IDLE, S_ISSUE, S_WAIT, S_RESP.
REQ-021 S_IDLE: if any port is in P_PEND, select a winner and go to S_ISSUE; otherwise stay.
REQ-022 Arbitration SHALL be round-robin; the search starts at port 1 after reset and at winner+1 after each grant, wrapping 4->1.
REQ-023 S_ISSUE: drive alu_req=1 for exactly one cycle with the winner's cmd/op1/op2, then go to S_WAIT; alu_* outputs SHALL be 0 otherwise.
REQ-024 S_WAIT: on alu_done=1, capture alu_resp/alu_data and go to S_RESP.
REQ-025 S_WAIT: a cycle counter SHALL increment each cycle; on reaching ALU_TIMEOUT without alu_done, capture resp=3, data=0 and go to S_RESP.
REQ-026 alu_done SHALL be ignored outside S_WAIT, including a late done after timeout.
REQ-027 S_RESP: drive the winner's out_resp/out_data for exactly one cycle, return that port to P_IDLE, then go to S_IDLE.
REQ-028 A command presented on a port in the same cycle its out_resp is nonzero SHALL be accepted.
REQ-029 All out_resp/out_data SHALL be registered and 0 in any cycle with no response for that port.
REQ-030 Minimum latency SHALL be: command at cycle T, op2 at T+1, alu_req at T+3, alu_done at T+4 -> out_resp valid at T+5.
REQ-031 An invalid-command response and a scheduler response on different ports in the same cycle SHALL both be delivered.
REQ-032 Operand and result data SHALL pass through unmodified, with no arithmetic in this block.

Reset
REQ-033 While reset=0, all FSMs SHALL be idle, the counter 0, the round-robin pointer at port 1, and all outputs 0.
REQ-034 Reset mid-operation SHALL discard all pending and in-flight requests with no response; alu_done after reset release SHALL be ignored.

Verification
REQ-035 Port1 ADD 0xFFFF0000, 0x0000FFFF; ALU done after 1 cycle with resp=1, data=0xFFFFFFFF -> alu_req at T+3 with op1/op2 correct; out_resp[1]=1, out_data[1]=0xFFFFFFFF at T+5.
REQ-036 Ports 1-4 issue LSH in the same cycle -> ALU grants in order 1,2,3,4, one alu_req per operation; each port gets exactly one response.
REQ-037 Port2 cmd=3 with operands 5, 7 -> alu_req never asserts; out_resp[2]=2, out_data[2]=0 for one cycle.
REQ-038 Port3 SUB with no alu_done -> out_resp[3]=3, out_data=0 after ALU_TIMEOUT cycles in WAIT; a later alu_done is ignored.
REQ-039 Reset asserted in S_WAIT, then alu_done after release -> no out_resp on any port; a new port-1 request completes normally.
REQ-040 After port 4 is granted, ports 1 and 4 become pending together -> port 1 is granted first.

Source files
------------

// File: rtl/calc1_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : calc1_arbiter
// Description : Four-port command capture front end sharing one ALU.
//               Each port collects a command plus two operands, then a
//               round-robin scheduler issues pending operations to the ALU,
//               waits for completion or timeout, and routes the response back.
// Revision    : 1.0 - initial release
// ============================================================================
module calc1_arbiter #(
    parameter int ALU_TIMEOUT = 15
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req_cmd_in  [1:4],
    input  logic [31:0] req_data_in [1:4],
    output logic [1:0]  out_resp    [1:4],
    output logic [31:0] out_data    [1:4],
    output logic        alu_req,
    output logic [3:0]  alu_cmd,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    input  logic        alu_done,
    input  logic [1:0]  alu_resp,
    input  logic [31:0] alu_data
);

    localparam int NPORT = 4;
    localparam int CNT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
    // Counter value on the last WAIT cycle before the operation is aborted
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_OP2  = 2'd1,
        P_PEND = 2'd2
    } port_state_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_e;

    // Per-port capture state
    port_state_e pst_q   [NPORT];
    port_state_e pst_d   [NPORT];
    logic [3:0]  cmd_q   [NPORT];
    logic [3:0]  cmd_d   [NPORT];
    logic [31:0] op1_q   [NPORT];
    logic [31:0] op1_d   [NPORT];
    logic [31:0] op2_q   [NPORT];
    logic [31:0] op2_d   [NPORT];
    logic [1:0]  resp_q  [NPORT];
    logic [1:0]  resp_d  [NPORT];
    logic [31:0] rdata_q [NPORT];
    logic [31:0] rdata_d [NPORT];

    logic [NPORT-1:0] w_pend;
    logic [NPORT-1:0] w_release;

    // Scheduler state
    sched_state_e     sst_q, sst_d;
    logic [1:0]       win_q, win_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       w_sel;
    logic             w_fire;
    logic [1:0]       w_cap_resp;
    logic [31:0]      w_cap_data;

    function automatic logic cmd_valid(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
    endfunction

    // Ports waiting for the ALU
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < NPORT; i++) begin
            w_pend[i] = (pst_q[i] == P_PEND);
        end
    end

    // Round-robin pick: first pending port at or after the pointer
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found = 1'b0;
        idx   = ptr_q;
        w_sel = ptr_q;
        for (int k = 0; k < NPORT; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && w_pend[idx]) begin
                w_sel = idx;
                found = 1'b1;
            end
        end
    end

    // Scheduler next state, ALU issue outputs and completion capture
    always_comb begin
        sst_d      = sst_q;
        win_d      = win_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        w_fire     = 1'b0;
        w_cap_resp = 2'd3;
        w_cap_data = '0;
        w_release  = '0;
        alu_req    = 1'b0;
        alu_cmd    = '0;
        alu_op1    = '0;
        alu_op2    = '0;
        case (sst_q)
            S_IDLE: begin
                if (|w_pend) begin
                    win_d = w_sel;
                    ptr_d = w_sel + 2'd1;
                    sst_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_req = 1'b1;
                alu_cmd = cmd_q[win_q];
                alu_op1 = op1_q[win_q];
                alu_op2 = op2_q[win_q];
                cnt_d   = '0;
                sst_d   = S_WAIT;
            end
            S_WAIT: begin
                if (alu_done) begin
                    w_fire     = 1'b1;
                    w_cap_resp = alu_resp;
                    w_cap_data = alu_data;
                    sst_d      = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // Timeout: response code 3 with zero data
                    w_fire = 1'b1;
                    sst_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                cnt_d = '0;
                sst_d = S_IDLE;
            end
            default: sst_d = S_IDLE;
        endcase
        if (w_fire) begin
            w_release[win_q] = 1'b1;
        end
    end

    // Per-port capture FSM and response register next values
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            pst_d[i]   = pst_q[i];
            cmd_d[i]   = cmd_q[i];
            op1_d[i]   = op1_q[i];
            op2_d[i]   = op2_q[i];
            resp_d[i]  = 2'd0;
            rdata_d[i] = '0;
            case (pst_q[i])
                P_IDLE: begin
                    if (req_cmd_in[i+1] != 4'd0) begin
                        cmd_d[i] = req_cmd_in[i+1];
                        op1_d[i] = req_data_in[i+1];
                        pst_d[i] = P_OP2;
                    end
                end
                P_OP2: begin
                    op2_d[i] = req_data_in[i+1];
                    if (cmd_valid(cmd_q[i])) begin
                        pst_d[i] = P_PEND;
                    end else begin
                        // Invalid command answered locally, never reaches the ALU
                        pst_d[i]  = P_IDLE;
                        resp_d[i] = 2'd2;
                    end
                end
                P_PEND: begin
                    // Port is freed on the completion edge so it can accept a
                    // new command while its response is on the outputs
                    if (w_release[i]) begin
                        pst_d[i]   = P_IDLE;
                        resp_d[i]  = w_cap_resp;
                        rdata_d[i] = w_cap_data;
                    end
                end
                default: pst_d[i] = P_IDLE;
            endcase
        end
    end

    // Per-port state and response registers
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPORT; i++) begin
                pst_q[i]   <= P_IDLE;
                cmd_q[i]   <= '0;
                op1_q[i]   <= '0;
                op2_q[i]   <= '0;
                resp_q[i]  <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                pst_q[i]   <= pst_d[i];
                cmd_q[i]   <= cmd_d[i];
                op1_q[i]   <= op1_d[i];
                op2_q[i]   <= op2_d[i];
                resp_q[i]  <= resp_d[i];
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

    // Scheduler registers
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            sst_q <= S_IDLE;
            win_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            sst_q <= sst_d;
            win_q <= win_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Map internal response registers onto the 1-based output ports
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            out_resp[i+1] = resp_q[i];
            out_data[i+1] = rdata_q[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc1_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc1_arbiter
// Description : Self-checking bench for calc1_arbiter: directed vector table
//               for single-port operations plus hand-written sequences for
//               arbitration, timeout and reset corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc1_arbiter;

    localparam int TO = 15;

    logic        c_clk = 1'b0;
    logic        reset;
    logic [3:0]  req_cmd_in  [1:4];
    logic [31:0] req_data_in [1:4];
    logic [1:0]  out_resp    [1:4];
    logic [31:0] out_data    [1:4];
    logic        alu_req;
    logic [3:0]  alu_cmd;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic        alu_done;
    logic [1:0]  alu_resp;
    logic [31:0] alu_data;

    int n_chk  = 0;
    int n_fail = 0;

    bit mon_en = 1'b0;
    int n_req  = 0;
    int n_resp [1:4];

    typedef struct {
        int          port;
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        int          dly;
        logic [1:0]  aresp;
        logic [31:0] adata;
        logic [1:0]  eresp;
        logic [31:0] edata;
    } vec_t;

    vec_t vecs [6];

    always #5 c_clk = ~c_clk;

    calc1_arbiter #(.ALU_TIMEOUT(TO)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .alu_req     (alu_req),
        .alu_cmd     (alu_cmd),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_done    (alu_done),
        .alu_resp    (alu_resp),
        .alu_data    (alu_data)
    );

    // Count ALU issues and per-port responses in a monitored window
    always @(negedge c_clk) begin
        if (mon_en) begin
            if (alu_req === 1'b1) n_req++;
            for (int p = 1; p <= 4; p++) begin
                if (out_resp[p] !== 2'd0) n_resp[p]++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int p = 1; p <= 4; p++) begin
            req_cmd_in[p]  = 4'd0;
            req_data_in[p] = 32'd0;
        end
        alu_done = 1'b0;
        alu_resp = 2'd0;
        alu_data = 32'd0;
    endtask

    task automatic mon_start();
        n_req = 0;
        for (int p = 1; p <= 4; p++) n_resp[p] = 0;
        mon_en = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // One single-port operation with cycle-exact latency checks
    task automatic run_vec(input vec_t v, input int idx);
        bit valid;
        valid = (v.cmd == 4'd1) || (v.cmd == 4'd2) || (v.cmd == 4'd5) || (v.cmd == 4'd6);
        req_cmd_in[v.port]  = v.cmd;
        req_data_in[v.port] = v.op1;
        tick();                                   // T+1
        req_cmd_in[v.port]  = 4'd0;
        req_data_in[v.port] = v.op2;
        tick();                                   // T+2
        req_data_in[v.port] = 32'd0;
        if (!valid) begin
            chk($sformatf("v%0d inv resp", idx), 32'(out_resp[v.port]), 32'(v.eresp));
            chk($sformatf("v%0d inv data", idx), out_data[v.port], v.edata);
            chk($sformatf("v%0d inv no req", idx), 32'(alu_req), 32'd0);
            tick();                               // T+3
            chk($sformatf("v%0d inv one cycle", idx), 32'(out_resp[v.port]), 32'd0);
            chk($sformatf("v%0d inv no req2", idx), 32'(alu_req), 32'd0);
        end else begin
            chk($sformatf("v%0d req early", idx), 32'(alu_req), 32'd0);
            tick();                               // T+3
            chk($sformatf("v%0d alu_req", idx), 32'(alu_req), 32'd1);
            chk($sformatf("v%0d alu_cmd", idx), 32'(alu_cmd), 32'(v.cmd));
            chk($sformatf("v%0d alu_op1", idx), alu_op1, v.op1);
            chk($sformatf("v%0d alu_op2", idx), alu_op2, v.op2);
            tick();                               // T+4, first WAIT cycle
            chk($sformatf("v%0d req pulse", idx), 32'(alu_req), 32'd0);
            repeat (v.dly) tick();
            alu_done = 1'b1;
            alu_resp = v.aresp;
            alu_data = v.adata;
            tick();
            alu_done = 1'b0;
            alu_resp = 2'd0;
            alu_data = 32'd0;
            chk($sformatf("v%0d resp", idx), 32'(out_resp[v.port]), 32'(v.eresp));
            chk($sformatf("v%0d data", idx), out_data[v.port], v.edata);
            tick();
            chk($sformatf("v%0d resp clear", idx), 32'(out_resp[v.port]), 32'd0);
            chk($sformatf("v%0d data clear", idx), out_data[v.port], 32'd0);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;

        vecs[0] = '{1, 4'd1, 32'hFFFF0000, 32'h0000FFFF, 0, 2'd1, 32'hFFFFFFFF, 2'd1, 32'hFFFFFFFF};
        vecs[1] = '{2, 4'd3, 32'd5,        32'd7,        0, 2'd0, 32'd0,        2'd2, 32'd0};
        vecs[2] = '{3, 4'd2, 32'd10,       32'd3,        2, 2'd1, 32'd7,        2'd1, 32'd7};
        vecs[3] = '{2, 4'd1, 32'h7FFFFFFF, 32'd1,        1, 2'd2, 32'h80000000, 2'd2, 32'h80000000};
        vecs[4] = '{1, 4'd7, 32'd1,        32'd2,        0, 2'd0, 32'd0,        2'd2, 32'd0};
        vecs[5] = '{4, 4'd6, 32'h80000000, 32'd4,        0, 2'd1, 32'h08000000, 2'd1, 32'h08000000};

        // Reset state
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("rst alu_req", 32'(alu_req), 32'd0);
        chk("rst alu_cmd", 32'(alu_cmd), 32'd0);
        chk("rst alu_op1", alu_op1, 32'd0);
        chk("rst alu_op2", alu_op2, 32'd0);
        for (int p = 1; p <= 4; p++) begin
            chk($sformatf("rst resp%0d", p), 32'(out_resp[p]), 32'd0);
            chk($sformatf("rst data%0d", p), out_data[p], 32'd0);
        end
        reset = 1'b1;
        tick();

        // Directed single-port vectors (last one grants port 4)
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Ports 1 and 4 pending together after a port-4 grant; invalid
        // response on port 2 coincides with port 1's scheduler response;
        // port 1 re-issues during its own response cycle.
        req_cmd_in[1] = 4'd1; req_data_in[1] = 32'h11;
        req_cmd_in[4] = 4'd2; req_data_in[4] = 32'h44;
        tick();                                   // T+1
        req_cmd_in[1] = 4'd0; req_data_in[1] = 32'h12;
        req_cmd_in[4] = 4'd0; req_data_in[4] = 32'h45;
        tick();                                   // T+2
        req_data_in[1] = 32'd0; req_data_in[4] = 32'd0;
        tick();                                   // T+3
        chk("rr first req", 32'(alu_req), 32'd1);
        chk("rr first op1", alu_op1, 32'h11);
        chk("rr first op2", alu_op2, 32'h12);
        req_cmd_in[2] = 4'd4; req_data_in[2] = 32'd9;
        tick();                                   // T+4
        req_cmd_in[2] = 4'd0;
        alu_done = 1'b1; alu_resp = 2'd1; alu_data = 32'h23;
        tick();                                   // T+5
        alu_done = 1'b0; alu_resp = 2'd0; alu_data = 32'd0;
        req_data_in[2] = 32'd0;
        chk("dual resp1", 32'(out_resp[1]), 32'd1);
        chk("dual data1", out_data[1], 32'h23);
        chk("dual resp2", 32'(out_resp[2]), 32'd2);
        chk("dual data2", out_data[2], 32'd0);
        req_cmd_in[1] = 4'd2; req_data_in[1] = 32'h55;
        tick();                                   // T+6
        req_cmd_in[1] = 4'd0; req_data_in[1] = 32'h66;
        chk("dual resp1 clear", 32'(out_resp[1]), 32'd0);
        tick();                                   // T+7
        req_data_in[1] = 32'd0;
        chk("rr second req", 32'(alu_req), 32'd1);
        chk("rr second op1", alu_op1, 32'h44);
        chk("rr second cmd", 32'(alu_cmd), 32'd2);
        tick();                                   // T+8
        alu_done = 1'b1; alu_resp = 2'd2; alu_data = 32'hDEAD;
        tick();                                   // T+9
        alu_done = 1'b0; alu_resp = 2'd0; alu_data = 32'd0;
        chk("rr resp4", 32'(out_resp[4]), 32'd2);
        chk("rr data4", out_data[4], 32'hDEAD);
        tick();                                   // T+10
        tick();                                   // T+11
        chk("reissue req", 32'(alu_req), 32'd1);
        chk("reissue op1", alu_op1, 32'h55);
        chk("reissue op2", alu_op2, 32'h66);
        tick();                                   // T+12
        alu_done = 1'b1; alu_resp = 2'd1; alu_data = 32'h77;
        tick();                                   // T+13
        alu_done = 1'b0; alu_resp = 2'd0; alu_data = 32'd0;
        chk("reissue resp1", 32'(out_resp[1]), 32'd1);
        chk("reissue data1", out_data[1], 32'h77);
        tick();

        // Port 3 timeout with a late alu_done
        req_cmd_in[3] = 4'd2; req_data_in[3] = 32'h30;
        tick();
        req_cmd_in[3] = 4'd0; req_data_in[3] = 32'h31;
        tick();
        req_data_in[3] = 32'd0;
        tick();                                   // T+3
        chk("to req", 32'(alu_req), 32'd1);
        tick();                                   // T+4, first WAIT cycle
        repeat (TO - 1) tick();                   // T+18, last WAIT cycle
        chk("to early", 32'(out_resp[3]), 32'd0);
        tick();                                   // T+19
        chk("to resp", 32'(out_resp[3]), 32'd3);
        chk("to data", out_data[3], 32'd0);
        tick();
        alu_done = 1'b1; alu_resp = 2'd1; alu_data = 32'h99;
        tick();
        alu_done = 1'b0; alu_resp = 2'd0; alu_data = 32'd0;
        mon_start();
        repeat (4) tick();
        mon_en = 1'b0;
        chk("late done resp3", 32'(n_resp[3]), 32'd0);
        chk("late done req", 32'(n_req), 32'd0);

        // Reset while waiting on the ALU, then a stale alu_done
        req_cmd_in[1] = 4'd1; req_data_in[1] = 32'hAAAA;
        tick();
        req_cmd_in[1] = 4'd0; req_data_in[1] = 32'hBBBB;
        tick();
        req_data_in[1] = 32'd0;
        tick();
        chk("rw req", 32'(alu_req), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rw in reset req", 32'(alu_req), 32'd0);
        tick();
        reset = 1'b1;
        mon_start();
        tick();
        alu_done = 1'b1; alu_resp = 2'd1; alu_data = 32'hCAFE;
        tick();
        alu_done = 1'b0; alu_resp = 2'd0; alu_data = 32'd0;
        repeat (4) tick();
        mon_en = 1'b0;
        chk("rw no resp", 32'(n_resp[1] + n_resp[2] + n_resp[3] + n_resp[4]), 32'd0);
        chk("rw no req", 32'(n_req), 32'd0);
        run_vec(vecs[0], 10);

        // Four simultaneous LSH requests after reset: grants 1,2,3,4
        do_reset();
        mon_start();
        for (int p = 1; p <= 4; p++) begin
            req_cmd_in[p] = 4'd5; req_data_in[p] = 32'h100 + 32'(p);
        end
        tick();
        for (int p = 1; p <= 4; p++) begin
            req_cmd_in[p] = 4'd0; req_data_in[p] = 32'(p);
        end
        tick();
        for (int p = 1; p <= 4; p++) req_data_in[p] = 32'd0;
        for (int g = 1; g <= 4; g++) begin
            w = 0;
            while (alu_req !== 1'b1 && w < 30) begin
                tick();
                w++;
            end
            chk($sformatf("all4 wait g%0d", g), 32'(w < 30), 32'd1);
            chk($sformatf("all4 op1 g%0d", g), alu_op1, 32'h100 + 32'(g));
            chk($sformatf("all4 op2 g%0d", g), alu_op2, 32'(g));
            chk($sformatf("all4 cmd g%0d", g), 32'(alu_cmd), 32'd5);
            tick();
            alu_done = 1'b1; alu_resp = 2'd1; alu_data = 32'hA0 + 32'(g);
            tick();
            alu_done = 1'b0; alu_resp = 2'd0; alu_data = 32'd0;
            chk($sformatf("all4 resp g%0d", g), 32'(out_resp[g]), 32'd1);
            chk($sformatf("all4 data g%0d", g), out_data[g], 32'hA0 + 32'(g));
        end
        repeat (4) tick();
        mon_en = 1'b0;
        chk("all4 req count", 32'(n_req), 32'd4);
        for (int p = 1; p <= 4; p++) begin
            chk($sformatf("all4 resp count p%0d", p), 32'(n_resp[p]), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
